// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU request sequencer: opcodes, FSM states, default widths
// and the opcode legality check.
package alu_seq_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_OP_W   = 4;

    localparam logic [DEF_OP_W-1:0] OP_ADD   = 4'd1;
    localparam logic [DEF_OP_W-1:0] OP_SUB   = 4'd2;
    localparam logic [DEF_OP_W-1:0] OP_MUL   = 4'd3;
    localparam logic [DEF_OP_W-1:0] OP_MOD   = 4'd4;
    localparam logic [DEF_OP_W-1:0] OP_PASSA = 4'd5;
    localparam logic [DEF_OP_W-1:0] OP_PASSB = 4'd6;
    localparam logic [DEF_OP_W-1:0] OP_INCA  = 4'd7;
    localparam logic [DEF_OP_W-1:0] OP_DECA  = 4'd8;
    localparam logic [DEF_OP_W-1:0] OP_RESET = 4'd9;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } seq_state_e;

    function automatic logic is_legal_op(input logic [DEF_OP_W-1:0] op);
        return (op >= OP_ADD) && (op <= OP_RESET);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. The last-grant pointer only moves when a grant is
// actually accepted, so a requester that withdraws costs nobody a turn.
module rr_arbiter2 (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic accept,
    output logic gnt0,
    output logic gnt1
);

    logic last_q;

    // On a tie, the port that was not granted last wins.
    always_comb begin
        gnt0 = req0 & (~req1 | last_q);
        gnt1 = req1 & (~req0 | ~last_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept && (gnt0 || gnt1)) begin
            last_q <= gnt1;
        end
    end

endmodule

// File: rtl/alu_request_sequencer.sv
// Arbitrates two masters onto the shared ALU, sequences issue/wait/capture and
// returns the captured result to the granted master as a one-cycle pulse.
module alu_request_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned OP_W    = DEF_OP_W,
    parameter int unsigned ALU_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_data,
    output logic              rsp0_zero,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_data,
    output logic              rsp1_zero,
    output logic              rsp1_err,
    output logic              alu_enable,
    output logic [OP_W-1:0]   alu_control,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_c,
    output logic              busy
);

    localparam int unsigned CNT_W = 4;

    seq_state_e state_q, state_d;

    logic              gnt0, gnt1;
    logic              idle, accept, sel_legal;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a, sel_b;

    logic [OP_W-1:0]   op_q;
    logic [DATA_W-1:0] a_q, b_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              grant_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q, err_q;

    rr_arbiter2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0_valid),
        .req1   (req1_valid),
        .accept (accept),
        .gnt0   (gnt0),
        .gnt1   (gnt1)
    );

    always_comb begin
        idle      = (state_q == StIdle);
        accept    = idle && (gnt0 || gnt1);
        sel_op    = gnt1 ? req1_op : req0_op;
        sel_a     = gnt1 ? req1_a  : req0_a;
        sel_b     = gnt1 ? req1_b  : req0_b;
        sel_legal = is_legal_op(sel_op);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (accept) state_d = sel_legal ? StIssue : StDone;
            StIssue: state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Operands stay latched after capture so the ALU buses hold their last value in idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            grant_q  <= 1'b0;
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        grant_q <= gnt1;
                        if (sel_legal) begin
                            op_q  <= sel_op;
                            a_q   <= sel_a;
                            b_q   <= sel_b;
                            err_q <= 1'b0;
                        end else begin
                            result_q <= '0;
                            zero_q   <= 1'b1;
                            err_q    <= 1'b1;
                        end
                    end
                end
                StIssue: cnt_q <= CNT_W'(ALU_LAT - 1);
                StWait: begin
                    if (cnt_q == '0) begin
                        result_q <= alu_c;
                        zero_q   <= (alu_c == '0);
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        req0_ready  = idle && gnt0;
        req1_ready  = idle && gnt1;
        busy        = !idle;
        alu_enable  = (state_q == StIssue);
        alu_control = op_q;
        alu_a       = a_q;
        alu_b       = b_q;
        rsp0_valid  = (state_q == StDone) && !grant_q;
        rsp1_valid  = (state_q == StDone) && grant_q;
        rsp0_data   = result_q;
        rsp1_data   = result_q;
        rsp0_zero   = zero_q;
        rsp1_zero   = zero_q;
        rsp0_err    = err_q;
        rsp1_err    = err_q;
    end

endmodule

// File: tb/tb_alu_request_sequencer.sv
// Bench for alu_request_sequencer: a cycle-level transaction model checks every cycle,
// directed scenarios pin literal results, and a second instance covers ALU_LAT=1.
module tb_alu_request_sequencer;

    localparam int unsigned LAT  = 4;
    localparam int unsigned LAT1 = 1;
    localparam logic [31:0] JUNK = 32'hA5A5_5A5A;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        rsp0_zero, rsp1_zero, rsp0_err, rsp1_err;
    logic        alu_enable, busy;
    logic [3:0]  alu_control;
    logic [31:0] alu_a, alu_b, alu_c;

    logic        s_valid = 1'b0;
    logic [3:0]  s_op = '0;
    logic [31:0] s_a = '0, s_b = '0;
    logic        s_ready, s_r1_ready, s_rsp_valid, s_rsp1_valid;
    logic [31:0] s_rsp_data, s_rsp1_data;
    logic        s_rsp_zero, s_rsp1_zero, s_rsp_err, s_rsp1_err;
    logic        s_en, s_busy;
    logic [3:0]  s_ctl;
    logic [31:0] s_alu_a, s_alu_b, s_alu_c;

    alu_request_sequencer #(.DATA_W(32), .OP_W(4), .ALU_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_zero(rsp0_zero),
        .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_zero(rsp1_zero),
        .rsp1_err(rsp1_err),
        .alu_enable(alu_enable), .alu_control(alu_control), .alu_a(alu_a),
        .alu_b(alu_b), .alu_c(alu_c), .busy(busy)
    );

    alu_request_sequencer #(.DATA_W(32), .OP_W(4), .ALU_LAT(LAT1)) u_dut1 (
        .clk(clk), .rst(rst),
        .req0_valid(s_valid), .req0_ready(s_ready), .req0_op(s_op),
        .req0_a(s_a), .req0_b(s_b),
        .req1_valid(1'b0), .req1_ready(s_r1_ready), .req1_op(4'd0),
        .req1_a(32'd0), .req1_b(32'd0),
        .rsp0_valid(s_rsp_valid), .rsp0_data(s_rsp_data), .rsp0_zero(s_rsp_zero),
        .rsp0_err(s_rsp_err),
        .rsp1_valid(s_rsp1_valid), .rsp1_data(s_rsp1_data), .rsp1_zero(s_rsp1_zero),
        .rsp1_err(s_rsp1_err),
        .alu_enable(s_en), .alu_control(s_ctl), .alu_a(s_alu_a),
        .alu_b(s_alu_b), .alu_c(s_alu_c), .busy(s_busy)
    );

    function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        case (op)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd3: return a * b;
            4'd4: return (b == 0) ? a : a % b;
            4'd5: return a;
            4'd6: return b;
            4'd7: return a + 1;
            4'd8: return a - 1;
            default: return 32'd0;
        endcase
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALUs: result is on alu_c only in the single cycle LAT after the enable.
    int          due0 = -1, due1 = -1, en_cnt = 0;
    logic [31:0] res0 = '0, res1 = '0;
    always @(posedge clk) begin
        if (alu_enable) begin
            due0   <= cyc + LAT;
            res0   <= alu_fn(alu_control, alu_a, alu_b);
            en_cnt <= en_cnt + 1;
        end
        if (s_en) begin
            due1 <= cyc + LAT1;
            res1 <= alu_fn(s_ctl, s_alu_a, s_alu_b);
        end
    end
    assign alu_c   = (cyc == due0) ? res0 : JUNK;
    assign s_alu_c = (cyc == due1) ? res1 : JUNK;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction model: one outstanding op, response fixed cycles after accept.
    int          m_free = 0, m_en = -1, m_rsp = -1;
    logic        m_port = 1'b0, m_last = 1'b1, m_legal = 1'b0, m_err = 1'b0;
    logic [3:0]  m_op = '0;
    logic [31:0] m_a = '0, m_b = '0, m_data = '0;

    always @(negedge clk) begin : model
        int   t;
        logic idle, g, v0, v1;
        t = cyc;
        if (rst) begin
            check("reset ctrl", {req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_zero,
                  rsp1_zero, rsp0_err, rsp1_err, alu_enable, busy, alu_control}, '0);
            check("reset rsp data", {rsp0_data, rsp1_data}, '0);
            check("reset alu buses", {alu_a, alu_b}, '0);
            m_free = 0; m_en = -1; m_rsp = -1; m_last = 1'b1; m_legal = 1'b0;
        end else begin
            idle = (t >= m_free);
            v0   = req0_valid;
            v1   = req1_valid;
            check("busy", busy, !idle);
            check("alu_enable", alu_enable, t == m_en);
            if (m_legal && t >= m_en && t < m_rsp)
                check("alu buses", {alu_control, alu_a, alu_b}, {m_op, m_a, m_b});
            check("rsp0_valid", rsp0_valid, (t == m_rsp) && !m_port);
            check("rsp1_valid", rsp1_valid, (t == m_rsp) && m_port);
            if (t == m_rsp && !m_port)
                check("rsp0 payload", {rsp0_data, rsp0_zero, rsp0_err},
                      {m_data, m_data == 0, m_err});
            if (t == m_rsp && m_port)
                check("rsp1 payload", {rsp1_data, rsp1_zero, rsp1_err},
                      {m_data, m_data == 0, m_err});
            g = (v0 && v1) ? ~m_last : v1;
            check("req0_ready", req0_ready, idle && v0 && !g);
            check("req1_ready", req1_ready, idle && v1 && g);
            if (idle && (v0 || v1)) begin
                m_last  = g;
                m_port  = g;
                m_op    = g ? req1_op : req0_op;
                m_a     = g ? req1_a : req0_a;
                m_b     = g ? req1_b : req0_b;
                m_legal = (m_op >= 1) && (m_op <= 9);
                if (m_legal) begin
                    m_en   = t + 1;
                    m_rsp  = t + 2 + LAT;
                    m_data = alu_fn(m_op, m_a, m_b);
                    m_err  = 1'b0;
                end else begin
                    m_en   = -1;
                    m_rsp  = t + 1;
                    m_data = '0;
                    m_err  = 1'b1;
                end
                m_free = m_rsp + 1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic do_req(input logic port, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int t_acc, output int t_rsp,
                          output logic [31:0] d, output logic z, output logic e,
                          output logic en1, output logic [3:0] ctl1);
        t_acc = -1; t_rsp = -1; d = '0; z = 1'b0; e = 1'b0; en1 = 1'b0; ctl1 = '0;
        @(posedge clk); #1;
        if (!port) begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (port ? req1_ready : req0_ready) begin
                t_acc = cyc;
                break;
            end
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 0) begin
                en1  = alu_enable;
                ctl1 = alu_control;
            end
            if (port ? rsp1_valid : rsp0_valid) begin
                t_rsp = cyc;
                d     = port ? rsp1_data : rsp0_data;
                z     = port ? rsp1_zero : rsp0_zero;
                e     = port ? rsp1_err : rsp0_err;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int          ta, tr, n, seen, en0;
        logic [31:0] d;
        logic        z, e, en1;
        logic [3:0]  ctl1, order;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("idle busy after reset", busy, 1'b0);

        do_req(1'b0, 4'd1, 32'd5, 32'd7, ta, tr, d, z, e, en1, ctl1);
        check("add enable/control at T+1", {en1, ctl1}, {1'b1, 4'd1});
        check("add latency", tr - ta, 6);
        check("add result", {d, z, e}, {32'd12, 1'b0, 1'b0});

        do_req(1'b1, 4'd2, 32'd9, 32'd9, ta, tr, d, z, e, en1, ctl1);
        check("sub latency", tr - ta, 6);
        check("sub result", {d, z, e}, {32'd0, 1'b1, 1'b0});

        // Both masters request MUL continuously from reset.
        do_reset();
        req0_op = 4'd3; req0_a = 32'd3; req0_b = 32'd4;
        req1_op = 4'd3; req1_a = 32'd3; req1_b = 32'd4;
        req0_valid = 1'b1; req1_valid = 1'b1;
        n = 0; order = '0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                order[3-n] = rsp1_valid;
                check("tie mul result", rsp1_valid ? rsp1_data : rsp0_data, 32'd12);
                n++;
            end
        end
        @(posedge clk); #1 req0_valid = 1'b0; req1_valid = 1'b0;
        check("tie response count", n, 4);
        check("tie grant order", order, 4'b0101);
        repeat (8) @(posedge clk);

        en0 = en_cnt;
        do_req(1'b0, 4'b1100, 32'd1, 32'd2, ta, tr, d, z, e, en1, ctl1);
        check("illegal latency", tr - ta, 1);
        check("illegal result", {d, e}, {32'd0, 1'b1});
        repeat (3) @(posedge clk);
        check("illegal no alu_enable", en_cnt - en0, 0);

        // Reset lands while the MOD is waiting on the ALU.
        @(posedge clk); #1;
        req0_op = 4'd4; req0_a = 32'd65; req0_b = 32'd8; req0_valid = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req0_ready) begin
                seen = 1;
                break;
            end
        end
        check("mod accepted", seen, 1);
        @(posedge clk); #1 req0_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        check("reset mid-op outputs", {alu_enable, busy, rsp0_valid}, 3'b000);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rsp0_valid) seen++;
        end
        check("abandoned response", seen, 0);
        do_req(1'b1, 4'd7, 32'd41, 32'd0, ta, tr, d, z, e, en1, ctl1);
        check("inca latency", tr - ta, 6);
        check("inca result", {d, z, e}, {32'd42, 1'b0, 1'b0});

        // ALU_LAT=1 instance.
        @(posedge clk); #1;
        s_op = 4'd6; s_a = 32'd1; s_b = 32'hDEADBEEF; s_valid = 1'b1;
        ta = -1; tr = -1; d = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_ready) begin
                ta = cyc;
                break;
            end
        end
        @(posedge clk); #1 s_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (s_rsp_valid) begin
                tr = cyc;
                d  = s_rsp_data;
                break;
            end
        end
        check("lat1 latency", tr - ta, 3);
        check("lat1 passb result", d, 32'hDEADBEEF);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_request_sequencer.md
# alu_request_sequencer

Sequencer and two-way arbiter in front of the shared 32-bit ALU of the convolution processor. It accepts operation requests from two masters (port 0: instruction control unit, port 1: convolution address/accumulate engine), grants one at a time round-robin, drives the ALU enable, control and operand buses, and waits a fixed ALU latency. It then captures the result and returns it to the granted master. It owns all ALU sequencing, so masters never touch ALU timing directly.

## Interface
Parameters:
- DATA_W, 32, operand/result width
- OP_W, 4, ALU control code width
- ALU_LAT, 4, cycles from ALU enable to valid result on alu_c (legal range 1..15)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  OP_W  ALU control code
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands
- rsp0_valid / rsp1_valid  out  1  one-cycle result pulse, no backpressure
- rsp0_data / rsp1_data  out  DATA_W  result
- rsp0_zero / rsp1_zero  out  1  result == 0
- rsp0_err / rsp1_err  out  1  illegal opcode
- alu_enable  out  1  one-cycle issue strobe to ALU
- alu_control  out  OP_W  ALU operation code
- alu_a, alu_b  out  DATA_W  ALU operand buses
- alu_c  in  DATA_W  ALU result bus
- busy  out  1  high in every state except IDLE

## Operation
- Legal opcodes: 1 ADD, 2 SUB, 3 MUL, 4 MOD, 5 PASSA, 6 PASSB, 7 INCA, 8 DECA, 9 RESET. Codes 0 and 10..15 are illegal.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: the arbiter picks one valid requester, and only that port sees ready=1. The other port's ready stays 0.
  - Legal op: latch op/a/b and go to ISSUE.
  - Illegal op: go to DONE with err=1 and data 0. The ALU is not touched.
- Arbitration: a single requester always wins. When both are valid, the port not granted last wins. last_grant resets to 1, so port 0 wins the first tie. last_grant updates only on accept.
- ISSUE: alu_enable=1 for exactly one cycle. alu_control/alu_a/alu_b carry the latched values. Load wait counter with ALU_LAT-1 and go to WAIT.
- WAIT: decrement the counter. At 0, capture alu_c into the result register and compute zero = (alu_c == 0), then go to DONE.
- DONE: the granted port's rsp_valid=1 with data/zero/err for one cycle, then go to IDLE. The non-granted rsp_valid stays 0.
- alu_control/alu_a/alu_b hold stable from ISSUE through capture. They keep their last value in IDLE.
- The zero flag is computed locally and does not depend on any ALU flag output.

## Timing
- Reset: state IDLE; all ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_enable, alu_control, alu_a, alu_b and busy are 0; last_grant=1.
- Legal op accepted in cycle T:
  - ISSUE in T+1
  - WAIT in T+2..T+1+ALU_LAT, capture at the end of T+1+ALU_LAT
  - rsp_valid in T+2+ALU_LAT
- Illegal op accepted in cycle T: rsp_valid with err=1 in T+1.
- Throughput: the next accept can happen no earlier than the cycle after DONE. With ALU_LAT=4, that is one legal op per 7 cycles.
- Reset asserted mid-operation: the response is abandoned, so no rsp_valid fires. alu_enable drops immediately and the FSM restarts in IDLE.
- A requester that drops valid before ready is simply not served. There is no penalty to last_grant.
- req inputs change while busy: ignored, because operands are latched at accept.

## Structure
- Package alu_seq_pkg holds:
  - opcode localparams (ADD..RESET)
  - state enum (IDLE, ISSUE, WAIT, DONE)
  - OP_W/DATA_W defaults
  - is_legal_op function
- One sub-module, rr_arbiter2: a 2-input round-robin arbiter with last_grant register, async active-high reset, and an update-on-accept input. The FSM, operand latches, wait counter and response registers live in the top.

## Test plan
- After reset, req0 ADD a=5 b=7 (ALU_LAT=4) -> req0_ready in accept cycle T; alu_enable pulses in T+1 with alu_control=1; rsp0_valid in T+6 with data=12, zero=0, err=0.
- req1 SUB a=9 b=9 -> rsp1_valid with data=0, zero=1, and rsp0_valid stays 0.
- req0 and req1 valid simultaneously from reset, each repeating MUL a=3 b=4 -> grants alternate 0,1,0,1; each rsp pulse returns 12 only on its own port.
- req0 op=4'b1100 -> rsp0_valid in the cycle after accept with err=1 and data=0; alu_enable never asserted.
- req0 MOD a=65 accepted; assert rst during WAIT -> no rsp0_valid, all outputs 0. A following req1 INCA a=41 then returns 42 with normal latency.
- ALU_LAT=1 build, req0 PASSB b=32'hDEADBEEF -> rsp0_valid three cycles after accept with data 32'hDEADBEEF.
